// File: rtl/damage_sequencer_pkg.sv
// Shared definitions for the damage sequencer and the damage datapath's move decoder.
package damage_sequencer_pkg;

    localparam int STATE_W    = 4;
    localparam int TURN_CNT_W = 8;

    localparam logic [STATE_W-1:0] ST_IDLE   = 4'd0;
    localparam logic [STATE_W-1:0] ST_LATCH  = 4'd1;
    localparam logic [STATE_W-1:0] ST_CALC   = 4'd2;
    localparam logic [STATE_W-1:0] ST_COMMIT = 4'd3;
    localparam logic [STATE_W-1:0] ST_CHECK  = 4'd4;
    localparam logic [STATE_W-1:0] ST_DECR   = 4'd5;
    localparam logic [STATE_W-1:0] ST_DRAW   = 4'd6;
    localparam logic [STATE_W-1:0] ST_DONE   = 4'd7;
    localparam logic [STATE_W-1:0] ST_OVER   = 4'd8;
    localparam logic [STATE_W-1:0] ST_FAULT  = 4'd9;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_LATCH  = ST_LATCH,
        S_CALC   = ST_CALC,
        S_COMMIT = ST_COMMIT,
        S_CHECK  = ST_CHECK,
        S_DECR   = ST_DECR,
        S_DRAW   = ST_DRAW,
        S_DONE   = ST_DONE,
        S_OVER   = ST_OVER,
        S_FAULT  = ST_FAULT
    } state_t;

    localparam logic [2:0] MV_NONE = 3'b000;
    localparam logic [2:0] MV_QA   = 3'b001;
    localparam logic [2:0] MV_TB   = 3'b010;
    localparam logic [2:0] MV_VT   = 3'b100;

    function automatic logic is_legal_move(input logic [2:0] mv);
        return (mv == MV_QA) || (mv == MV_TB) || (mv == MV_VT);
    endfunction

endpackage

// File: rtl/damage_sequencer_wait_timer.sv
// Handshake wait counter shared by the DECR and DRAW states.
module damage_sequencer_wait_timer #(
    parameter int WAIT_LIMIT = 4095,
    parameter int WAIT_W     = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_incr,
    output logic o_at_limit
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr) begin
            r_count <= r_count + 1'b1;
        end
    end

    // High when one more increment would reach WAIT_LIMIT.
    assign o_at_limit = (r_count == WAIT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/damage_sequencer.sv
// Turn-level sequencer driving the five datapath enables in fixed order for each accepted attack.
module damage_sequencer
    import damage_sequencer_pkg::*;
#(
    parameter int WAIT_LIMIT = 4095,
    parameter int WAIT_W     = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_move_valid,
    input  logic [2:0]            i_move_sel,
    input  logic                  i_done_decrement,
    input  logic                  i_done_damage,
    input  logic                  i_game_over,
    output logic [2:0]            o_attack_code,
    output logic                  o_enable_DMG_reg,
    output logic                  o_enable_DMG_calc,
    output logic                  o_enable_HP_calc,
    output logic                  o_enable_decrement_control,
    output logic                  o_enable_draw_decrease,
    output logic                  o_move_ready,
    output logic                  o_turn_done,
    output logic                  o_bad_move,
    output logic                  o_battle_over,
    output logic                  o_fault,
    output logic [TURN_CNT_W-1:0] o_turn_count
);

    state_t r_state;
    state_t w_next;
    logic   r_ko_flag;
    logic   w_accept;
    logic   w_reject;
    logic   w_clear;
    logic   w_incr;
    logic   w_at_limit;

    damage_sequencer_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .WAIT_W     (WAIT_W)
    ) u_wait_timer (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_incr     (w_incr),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A done input takes priority over the timeout in the same cycle.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_clear  = 1'b0;
        w_incr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_move_valid) begin
                    if (is_legal_move(i_move_sel)) begin
                        w_accept = 1'b1;
                        w_next   = S_LATCH;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_LATCH:  w_next = S_CALC;
            S_CALC:   w_next = S_COMMIT;
            S_COMMIT: w_next = S_CHECK;
            S_CHECK: begin
                w_clear = 1'b1;
                w_next  = S_DECR;
            end
            S_DECR: begin
                if (i_done_decrement) begin
                    w_clear = 1'b1;
                    w_next  = S_DRAW;
                end else begin
                    w_incr = 1'b1;
                    if (w_at_limit) w_next = S_FAULT;
                end
            end
            S_DRAW: begin
                if (i_done_damage) begin
                    w_next = r_ko_flag ? S_OVER : S_DONE;
                end else begin
                    w_incr = 1'b1;
                    if (w_at_limit) w_next = S_FAULT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_OVER:  w_next = S_OVER;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clock) begin
        if (!reset) begin
            o_attack_code              <= MV_NONE;
            o_enable_DMG_reg           <= 1'b0;
            o_enable_DMG_calc          <= 1'b0;
            o_enable_HP_calc           <= 1'b0;
            o_enable_decrement_control <= 1'b0;
            o_enable_draw_decrease     <= 1'b0;
            o_move_ready               <= 1'b1;
            o_turn_done                <= 1'b0;
            o_bad_move                 <= 1'b0;
            o_battle_over              <= 1'b0;
            o_fault                    <= 1'b0;
            o_turn_count               <= '0;
            r_ko_flag                  <= 1'b0;
        end else begin
            if (w_accept) o_attack_code <= i_move_sel;
            o_enable_DMG_reg           <= (w_next == S_LATCH);
            o_enable_DMG_calc          <= (w_next == S_CALC);
            o_enable_HP_calc           <= (w_next == S_COMMIT);
            o_enable_decrement_control <= (w_next == S_DECR);
            o_enable_draw_decrease     <= (w_next == S_DRAW);
            o_move_ready               <= (w_next == S_IDLE);
            o_turn_done                <= (w_next == S_DONE);
            o_bad_move                 <= w_reject;
            if (w_next == S_OVER)  o_battle_over <= 1'b1;
            if (w_next == S_FAULT) o_fault       <= 1'b1;
            if (r_state == S_CHECK) r_ko_flag <= i_game_over;
            if ((w_next == S_DONE) && (o_turn_count != {TURN_CNT_W{1'b1}})) begin
                o_turn_count <= o_turn_count + 1'b1;
            end
        end
    end

endmodule
